maxpool_reduce: RTL

MAXPOOL_REDUCE -- requirements
Module: maxpool_reduce

---
 rtl/maxpool_pkg.sv | 16 +
 rtl/fp_max_cmp.sv | 38 +++
 rtl/maxpool_reduce.sv | 80 ++++++++
 3 files changed

// File: rtl/maxpool_pkg.sv
// Shared defaults and bit-slicing helpers for the max-pooling reducer.
package maxpool_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_CH     = 4;
  localparam int DEF_POOL_N = 4;

  function automatic int sign_bit(input int w);
    return w - 1;
  endfunction

  function automatic int lane_lo(input int lane, input int w);
    return lane * w;
  endfunction

endpackage

// File: rtl/fp_max_cmp.sv
// Sign-magnitude maximum of two samples; a tie returns in_a.
module fp_max_cmp
  import maxpool_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic [DATA_W-1:0] max_out
);

  localparam int S = sign_bit(DATA_W);

  logic         sa;
  logic         sb;
  logic [S-1:0] ma;
  logic [S-1:0] mb;
  logic         b_wins;

  assign sa = in_a[S];
  assign sb = in_b[S];
  assign ma = in_a[S-1:0];
  assign mb = in_b[S-1:0];

  // Negative operands invert the magnitude order; -0 loses to +0 via sign
  always_comb begin
    b_wins = 1'b0;
    unique case ({sa, sb})
      2'b00:   b_wins = (mb > ma);
      2'b11:   b_wins = (mb < ma);
      2'b10:   b_wins = 1'b1;
      default: b_wins = 1'b0;
    endcase
  end

  assign max_out = b_wins ? in_b : in_a;

endmodule

// File: rtl/maxpool_reduce.sv
// Per-lane max pooling over POOL_N-beat windows with early close on in_last
// and a single registered result slot behind a valid/ready handshake.
module maxpool_reduce
  import maxpool_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CH     = DEF_CH,
  parameter int POOL_N = DEF_POOL_N
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CH*DATA_W-1:0] in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CH*DATA_W-1:0] out_data,
  output logic                 out_partial
);

  localparam int W     = CH * DATA_W;
  localparam int CNT_W = (POOL_N > 1) ? $clog2(POOL_N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POOL_N - 1);

  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     acc;
  logic [W-1:0]     cmp;
  logic [W-1:0]     merged;
  logic             accept;
  logic             closing;

  assign in_ready = enable && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign closing  = accept && ((cnt == CNT_LAST) || in_last);

  for (genvar l = 0; l < CH; l++) begin : g_lane
    fp_max_cmp #(
      .DATA_W(DATA_W)
    ) u_cmp (
      .in_a   (acc[lane_lo(l, DATA_W) +: DATA_W]),
      .in_b   (in_data[lane_lo(l, DATA_W) +: DATA_W]),
      .max_out(cmp[lane_lo(l, DATA_W) +: DATA_W])
    );
  end

  // First beat of a window ignores whatever is left in acc
  assign merged = (cnt == '0) ? in_data : cmp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      acc         <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_partial <= 1'b0;
    end else if (!enable) begin
      cnt         <= '0;
      acc         <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_partial <= 1'b0;
    end else if (closing) begin
      out_data    <= merged;
      out_valid   <= 1'b1;
      out_partial <= (cnt != CNT_LAST);
      cnt         <= '0;
    end else begin
      if (accept) begin
        acc <= merged;
        cnt <= cnt + 1'b1;
      end
      if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
